// File: rtl/bst_pkg.sv
// Shared types and sizes for the BST node selection path.
// Used by sw_debouncer and sw_select_decoder.
package bst_pkg;

    localparam int NODE_COUNT = 8;
    localparam int KEY_W      = 8;
    localparam int SW_W       = 10;

    typedef logic [KEY_W-1:0] key_t;
    typedef logic [2:0]       node_idx_t;

    // Selection status tuple; any change in it raises sel_change.
    typedef struct packed {
        logic      none;
        logic      error;
        node_idx_t idx;
    } sel_status_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sw_debouncer.sv
// Two-flop synchroniser plus whole-vector debouncer for the slide switches.
// Build macro SW_DEBOUNCE_EN: defined = debounce window, undefined = plain synchroniser.
module sw_debouncer
    import bst_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SW_W-1:0] sw,
    output logic [SW_W-1:0] stable
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
        $error("sw_debouncer: DEBOUNCE_CYCLES must be at least 2");
    end

    logic [SW_W-1:0] sync_meta;

`ifdef SW_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]  sync;
    logic [SW_W-1:0]  sync_prev;
    logic [CNT_W-1:0] cnt;
    logic             sync_moved;

    // A change only restarts the window once counting has begun; the first
    // differing cycle is itself the first counted cycle.
    assign sync_moved = (sync != sync_prev) && (cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync      <= '0;
            sync_prev <= '0;
            cnt       <= '0;
            stable    <= '0;
        end else begin
            sync_meta <= sw;
            sync      <= sync_meta;
            sync_prev <= sync;
            if (sync == stable) begin
                cnt <= '0;
            end else if (sync_moved) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    // stable is the second synchroniser stage, so SW reaches the outputs in 3 edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            stable    <= '0;
        end else begin
            sync_meta <= sw;
            stable    <= sync_meta;
        end
    end
`endif

endmodule

// File: rtl/sw_select_decoder.sv
// Debounced slide switches -> selected BST node key, error and none flags.
// Debounce window enabled by defining SW_DEBOUNCE_EN; otherwise synchroniser only.
module sw_select_decoder
    import bst_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SW_W-1:0]             SW,
    input  logic [NODE_COUNT*KEY_W-1:0] node_keys,
    output key_t                        value,
    output logic                        error,
    output logic                        none,
    output node_idx_t                   sel_idx,
    output logic                        sel_change
);

    logic [SW_W-1:0] stable;
    sel_status_t     status_d;
    sel_status_t     status_q;
    key_t            value_d;

    sw_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (SW),
        .stable(stable)
    );

    // none wins over error; only a single lit SW[7:0] bit yields a real selection.
    always_comb begin
        status_d.none  = (stable == '0);
        status_d.error = 1'b0;
        status_d.idx   = '0;
        value_d        = '0;
        if (!status_d.none) begin
            if ((stable[SW_W-1:NODE_COUNT] != '0) || (popcount8(stable[NODE_COUNT-1:0]) > 4'd1)) begin
                status_d.error = 1'b1;
            end else begin
                for (int i = 0; i < NODE_COUNT; i++) begin
                    if (stable[i]) begin
                        status_d.idx = node_idx_t'(i);
                        value_d      = node_keys[i*KEY_W +: KEY_W];
                    end
                end
            end
        end
    end

    assign status_q = '{none: none, error: error, idx: sel_idx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value      <= '0;
            error      <= 1'b0;
            none       <= 1'b1;
            sel_idx    <= '0;
            sel_change <= 1'b0;
        end else begin
            value      <= value_d;
            error      <= status_d.error;
            none       <= status_d.none;
            sel_idx    <= status_d.idx;
            sel_change <= (status_d != status_q);
        end
    end

endmodule

// File: tb/tb_sw_select_decoder.sv
// Directed bench for sw_select_decoder with DEBOUNCE_CYCLES = 4.
// Expected latencies follow SW_DEBOUNCE_EN: 7 edges with debounce, 3 without.
module tb_sw_select_decoder;
    import bst_pkg::*;

`ifdef SW_DEBOUNCE_EN
    localparam int LAT = 7;
    localparam int BOUNCE_PULSES = 0;
`else
    localparam int LAT = 3;
    localparam int BOUNCE_PULSES = 20;
`endif

    logic                        clk;
    logic                        rst_n;
    logic [SW_W-1:0]             sw;
    logic [NODE_COUNT*KEY_W-1:0] node_keys;
    key_t                        value;
    logic                        error;
    logic                        none;
    node_idx_t                   sel_idx;
    logic                        sel_change;

    int vectors;
    int miscompares;

    sw_select_decoder #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SW        (sw),
        .node_keys (node_keys),
        .value     (value),
        .error     (error),
        .none      (none),
        .sel_idx   (sel_idx),
        .sel_change(sel_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        sw        = 10'h3FF;
        node_keys = {8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd5};
        repeat (3) step();
        vectors++;
        if (value !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_value got=%0d exp=0", value);
        end
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_error got=%b exp=0", error);
        end
        vectors++;
        if (none !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_none got=%b exp=1", none);
        end
        vectors++;
        if (sel_idx !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_sel_idx got=%0d exp=0", sel_idx);
        end
        vectors++;
        if (sel_change !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_sel_change got=%b exp=0", sel_change);
        end
        sw    = 10'h000;
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            vectors++;
            if (sel_change !== 1'b0 || none !== 1'b1) begin
                miscompares++;
                $display("FAIL post_reset_idle cycle=%0d got sel_change=%b none=%b exp 0/1", k, sel_change, none);
            end
        end
    endtask

    task automatic test_select();
        sw = 10'h008;
        for (int k = 1; k <= LAT; k++) begin
            step();
            if (k < LAT) begin
                vectors++;
                if (none !== 1'b1 || sel_change !== 1'b0) begin
                    miscompares++;
                    $display("FAIL select_early edge=%0d got none=%b sel_change=%b exp 1/0", k, none, sel_change);
                end
            end
        end
        vectors++;
        if (value !== 8'd30 || sel_idx !== 3'd3 || none !== 1'b0 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL select_sw3 got value=%0d idx=%0d none=%b err=%b exp 30/3/0/0", value, sel_idx, none, error);
        end
        vectors++;
        if (sel_change !== 1'b1) begin
            miscompares++;
            $display("FAIL select_pulse got=%b exp=1", sel_change);
        end
        step();
        vectors++;
        if (sel_change !== 1'b0 || value !== 8'd30) begin
            miscompares++;
            $display("FAIL select_pulse_end got sel_change=%b value=%0d exp 0/30", sel_change, value);
        end
    endtask

    task automatic test_bounce();
        int pulses;
        sw = 10'h000;
        repeat (LAT + 2) step();
        pulses = 0;
        for (int p = 0; p < 10; p++) begin
            sw = 10'h004;
            repeat (2) begin
                step();
                if (sel_change === 1'b1) pulses++;
            end
            sw = 10'h000;
            repeat (2) begin
                step();
                if (sel_change === 1'b1) pulses++;
            end
        end
        repeat (6) begin
            step();
            if (sel_change === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != BOUNCE_PULSES) begin
            miscompares++;
            $display("FAIL bounce_pulses got=%0d exp=%0d", pulses, BOUNCE_PULSES);
        end
        vectors++;
        if (none !== 1'b1 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce_final got none=%b err=%b exp 1/0", none, error);
        end
    endtask

    task automatic test_illegal();
        logic [SW_W-1:0] pats [4];
        logic            exp_err [4];
        logic            exp_none [4];
        pats[0] = 10'h00C; exp_err[0] = 1'b1; exp_none[0] = 1'b0;
        pats[1] = 10'h000; exp_err[1] = 1'b0; exp_none[1] = 1'b1;
        pats[2] = 10'h200; exp_err[2] = 1'b1; exp_none[2] = 1'b0;
        pats[3] = 10'h000; exp_err[3] = 1'b0; exp_none[3] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            sw = pats[t];
            repeat (LAT) step();
            vectors++;
            if (error !== exp_err[t] || none !== exp_none[t] || value !== 8'd0 || sel_idx !== 3'd0) begin
                miscompares++;
                $display("FAIL illegal_%0d sw=%h got err=%b none=%b value=%0d idx=%0d exp %b/%b/0/0",
                         t, pats[t], error, none, value, sel_idx, exp_err[t], exp_none[t]);
            end
            vectors++;
            if (sel_change !== 1'b1) begin
                miscompares++;
                $display("FAIL illegal_pulse_%0d got=%b exp=1", t, sel_change);
            end
            step();
            vectors++;
            if (sel_change !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_pulse_end_%0d got=%b exp=0", t, sel_change);
            end
        end
    endtask

    task automatic test_key_update();
        sw = 10'h001;
        repeat (LAT + 2) step();
        vectors++;
        if (value !== 8'd5 || sel_idx !== 3'd0 || none !== 1'b0) begin
            miscompares++;
            $display("FAIL key_initial got value=%0d idx=%0d none=%b exp 5/0/0", value, sel_idx, none);
        end
        node_keys[7:0] = 8'd99;
        vectors++;
        if (value !== 8'd5) begin
            miscompares++;
            $display("FAIL key_before_edge got=%0d exp=5", value);
        end
        step();
        vectors++;
        if (value !== 8'd99 || sel_change !== 1'b0) begin
            miscompares++;
            $display("FAIL key_update got value=%0d sel_change=%b exp 99/0", value, sel_change);
        end
        node_keys[7:0] = 8'd5;
        step();
    endtask

    task automatic test_reset_mid_count();
        sw = 10'h010;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (value !== 8'd0 || error !== 1'b0 || none !== 1'b1 || sel_idx !== 3'd0 || sel_change !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_async got value=%0d err=%b none=%b idx=%0d chg=%b exp 0/0/1/0/0",
                     value, error, none, sel_idx, sel_change);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            step();
            if (k < LAT) begin
                vectors++;
                if (none !== 1'b1 || value !== 8'd0 || sel_change !== 1'b0) begin
                    miscompares++;
                    $display("FAIL midreset_hold edge=%0d got none=%b value=%0d chg=%b exp 1/0/0", k, none, value, sel_change);
                end
            end
        end
        vectors++;
        if (value !== 8'd40 || sel_idx !== 3'd4 || none !== 1'b0 || sel_change !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_accept got value=%0d idx=%0d none=%b chg=%b exp 40/4/0/1", value, sel_idx, none, sel_change);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        sw          = '0;
        node_keys   = '0;
        test_reset();
        test_select();
        test_bounce();
        test_select();
        test_illegal();
        test_key_update();
        test_reset_mid_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sw_select_decoder.md
# sw_select_decoder

Synchronises and debounces the ten board slide switches, then turns the stable switch pattern into the selection status for the two-digit hex display stage. Only SW[7:0] are valid single-node selectors. The block reports three things: the 8-bit key of the selected BST node, an error flag when the selection is illegal, and a none flag when every switch is off. It sits between the raw board switch inputs and the two-digit display driver, and drives that driver's value/error/none inputs directly.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive cycles a changed switch vector must hold before it is accepted (10 ms at 50 MHz); minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES): debounce counter width; derived, not overridden.

- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- SW  in  10  raw slide switches, asynchronous to clk
- node_keys  in  64  eight 8-bit node keys; node i is at [8i+7:8i]; synchronous to clk
- value  out  8  key of the selected node; 0 when none or error
- error  out  1  illegal selection: SW8 or SW9 on, or more than one of SW[7:0] on
- none  out  1  all ten stable switches off
- sel_idx  out  3  index of the selected node; 0 when none or error
- sel_change  out  1  one-cycle pulse whenever {none, error, sel_idx} changes

## Operation
- Synchroniser: SW passes through a 2-flop synchroniser to give sync[9:0].
- Debounce, using one shared counter over the whole vector:
  - sync == stable: counter cleared.
  - sync != stable and sync unchanged since the previous cycle: counter increments.
  - sync changes while counting: counter restarts at 0.
  - counter == DEBOUNCE_CYCLES-1 and sync still != stable: stable <= sync, counter <= 0.
- Decode is combinational on stable. The results are registered into the outputs.
  - none = (stable == 0).
  - error = !none && (stable[9:8] != 0 || popcount(stable[7:0]) > 1).
  - Otherwise exactly one bit i of stable[7:0] is set: sel_idx = i, value = node_keys[8i+7:8i].
- none has priority over error. error and none are never both 1.
- value re-samples node_keys every cycle. A key change with a steady selection updates value after 1 cycle and does not pulse sel_change.
- sel_change compares the newly registered {none, error, sel_idx} with the previous registered value. It is registered alongside the outputs.

## Timing
- Reset, asynchronous: sync = 0, stable = 0, counter = 0, value = 0, error = 0, none = 1, sel_idx = 0, sel_change = 0.
- First cycle after reset release: sel_change stays 0. Reset state is the baseline.
- Latency from an SW edge (held) to the outputs is 2 (sync) + DEBOUNCE_CYCLES + 1 (output register) clock edges.
- Bounce shorter than DEBOUNCE_CYCLES never reaches stable.
- A bounce returning to the old stable value clears the counter, so there is no output change.
- Several switches changing in different cycles: the last change restarts the window, and the whole vector is accepted at once.
- rst_n asserted mid-count discards the count and forces the reset values immediately.
- node_keys to value latency is 1 cycle.

## Configuration
- SW_DEBOUNCE_EN defined: debouncer as above.
- SW_DEBOUNCE_EN undefined:
  - counter is removed and stable <= sync every cycle;
  - SW to output latency is exactly 3 edges;
  - DEBOUNCE_CYCLES is ignored.
- Intended for simulation and fast bring-up only.

## Structure
- Shared package bst_pkg:
  - NODE_COUNT = 8, KEY_W = 8, SW_W = 10;
  - typedef key_t (logic [KEY_W-1:0]);
  - typedef node_idx_t (logic [2:0]).
- Sub-module sw_debouncer holds the synchroniser, counter and stable register, with parameter DEBOUNCE_CYCLES and a `ifdef SW_DEBOUNCE_EN` bypass.
- sw_select_decoder instantiates sw_debouncer and contains the decode, output registers and sel_change logic.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and node_keys = {8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd5}.

- Reset held, SW = 10'h3FF -> value 0, error 0, none 1, sel_idx 0, sel_change 0. After release with SW = 0 there is no sel_change pulse.
- SW = 10'h008 held -> exactly 7 edges later: value 30, sel_idx 3, none 0, error 0, with a single 1-cycle sel_change.
- SW toggles 0 -> 10'h004 -> 0 with 2-cycle pulses for 40 cycles -> none stays 1 and sel_change never asserts.
- Illegal selections, each accepted after debounce:
  - SW = 10'h00C -> error 1, value 0.
  - SW = 10'h200 -> error 1.
  - SW = 0 -> none 1, error 0.
  - Each transition produces one sel_change.
- With SW = 10'h001 stable, change node_keys[7:0] from 5 to 99 -> value 99 one cycle later, sel_change stays 0.
- Hold SW = 10'h010 for 3 cycles past sync, assert rst_n low for 1 cycle, release -> outputs hold reset values, and 10'h010 is accepted only after a full fresh window (7 edges from release).
